// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int unsigned width = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [width-1:0] OperandA,
    input  logic [width-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [width-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [width-1:0] Hi,
    output logic [width-1:0] Lo
);
    localparam int unsigned CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [CW-1:0]      r_cnt,    w_cnt_nxt;
    logic               r_is_div, w_is_div_nxt;
    logic               r_neg,    w_neg_nxt;
    logic               r_sign_a, w_sign_a_nxt;
    logic [width-1:0]   r_opnd,   w_opnd_nxt;
    logic [2*width-1:0] r_acc,    w_acc_nxt;
    logic [width-1:0]   r_rem,    w_rem_nxt;
    logic [width-1:0]   r_hi,     w_hi_nxt;
    logic [width-1:0]   r_lo,     w_lo_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_done,   w_done_nxt;
    logic               r_dbz,    w_dbz_nxt;

    // Operand capture: magnitudes for signed ops, raw values otherwise
    logic             w_sa;
    logic             w_sb;
    logic [width-1:0] w_abs_a;
    logic [width-1:0] w_abs_b;
    assign w_sa    = ~Op[0] & OperandA[width-1];
    assign w_sb    = ~Op[0] & OperandB[width-1];
    assign w_abs_a = w_sa ? ('0 - OperandA) : OperandA;
    assign w_abs_b = w_sb ? ('0 - OperandB) : OperandB;

    // Multiply step: conditional add into upper half, then shift right
    logic [width-1:0] w_addend;
    logic [width:0]   w_sum;
    assign w_addend = r_acc[0] ? r_opnd : '0;
    assign w_sum    = {1'b0, r_acc[2*width-1:width]} + {1'b0, w_addend};

    // Divide step: shift next dividend bit into the partial remainder, trial subtract
    logic [width:0]   w_shift;
    logic             w_ge;
    logic [width-1:0] w_diff;
    assign w_shift = {r_rem, r_acc[width-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[width-1:0] - r_opnd;

    logic [2*width-1:0] w_prod;
    logic [width-1:0]   w_quo;
    logic [width-1:0]   w_remf;
    assign w_prod = r_neg ? ('0 - r_acc) : r_acc;
    assign w_quo  = r_neg ? ('0 - r_acc[width-1:0]) : r_acc[width-1:0];
    assign w_remf = r_sign_a ? ('0 - r_rem) : r_rem;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_neg_nxt    = r_neg;
        w_sign_a_nxt = r_sign_a;
        w_opnd_nxt   = r_opnd;
        w_acc_nxt    = r_acc;
        w_rem_nxt    = r_rem;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_dbz_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt  = RUN;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = CW'(width);
                    w_is_div_nxt = Op[1];
                    w_neg_nxt    = w_sa ^ w_sb;
                    w_sign_a_nxt = w_sa;
                    w_rem_nxt    = '0;
                    w_opnd_nxt   = Op[1] ? w_abs_b : w_abs_a;
                    w_acc_nxt    = {{width{1'b0}}, (Op[1] ? w_abs_a : w_abs_b)};
                end else begin
                    if (WriteHi) w_hi_nxt = WriteData;
                    if (WriteLo) w_lo_nxt = WriteData;
                end
            end
            RUN: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_is_div) begin
                    w_rem_nxt = w_ge ? w_diff : w_shift[width-1:0];
                    w_acc_nxt = {r_acc[2*width-1:width], r_acc[width-2:0], w_ge};
                end else begin
                    w_acc_nxt = {w_sum, r_acc[width-1:1]};
                end
                if (r_cnt == CW'(1)) w_state_nxt = FIX;
            end
            FIX: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                if (r_is_div) begin
                    if (r_opnd == '0) begin
                        w_dbz_nxt = 1'b1;
                    end else begin
                        w_lo_nxt = w_quo;
                        w_hi_nxt = w_remf;
                    end
                end else begin
                    w_hi_nxt = w_prod[2*width-1:width];
                    w_lo_nxt = w_prod[width-1:0];
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_sign_a <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg    <= w_neg_nxt;
            r_sign_a <= w_sign_a_nxt;
            r_opnd   <= w_opnd_nxt;
            r_acc    <= w_acc_nxt;
            r_rem    <= w_rem_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign Hi        = r_hi;
    assign Lo        = r_lo;
endmodule
